// File: rtl/uart_mem_sequencer.sv
// uart_mem_sequencer: programs the SPART baud divisor, then serves 'W'/'R' frames received over
// the SPART bus as memory commands. Define UART_ACK_EN to send 0x06/0x15 response bytes.
module uart_mem_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  br_cfg,
    output logic        iocs,
    output logic        iorw,
    output logic [1:0]  ioaddr,
    input  logic        rda,
    input  logic        tbr,
    inout  wire  [7:0]  databus,
    output logic        mem_req,
    output logic        mem_we,
    output logic [23:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [7:0] OpWrite   = 8'h57;
    localparam logic [7:0] OpRead    = 8'h52;
`ifdef UART_ACK_EN
    localparam logic [7:0] RspAck    = 8'h06;
    localparam logic [7:0] RspNak    = 8'h15;
`endif
    localparam logic [1:0] AddrBuf   = 2'b00;
    localparam logic [1:0] AddrDivLo = 2'b10;
    localparam logic [1:0] AddrDivHi = 2'b11;

    typedef enum logic [3:0] {
        StCfgLo,
        StCfgHi,
        StIdle,
        StRxOp,
        StRxAddr,
        StRxData,
        StMemReq,
        StMemWait,
        StTxByte,
        StGap
    } state_e;

    state_e      state_q;
    state_e      ret_q;
    logic        iocs_q;
    logic        iorw_q;
    logic [1:0]  ioaddr_q;
    logic [7:0]  dout_q;
    logic [7:0]  div_hi_q;
    logic [31:0] rx_q;
    logic [31:0] tx_q;
    logic [2:0]  cnt_q;
    logic [2:0]  tx_n_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [23:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        op_we_q;

    function automatic logic [15:0] baud_div(input logic [1:0] sel);
        logic [15:0] div;
        case (sel)
            2'b00:   div = 16'h0515;
            2'b01:   div = 16'h028A;
            2'b10:   div = 16'h0145;
            default: div = 16'h00A2;
        endcase
        return div;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StCfgLo;
            ret_q       <= StIdle;
            iocs_q      <= 1'b0;
            iorw_q      <= 1'b1;
            ioaddr_q    <= AddrBuf;
            dout_q      <= 8'h00;
            div_hi_q    <= 8'h00;
            rx_q        <= 32'h0;
            tx_q        <= 32'h0;
            cnt_q       <= 3'd0;
            tx_n_q      <= 3'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 24'h0;
            mem_wdata_q <= 32'h0;
            op_we_q     <= 1'b0;
        end else begin
            // Every SPART access lasts one cycle; the following GAP cycle drops iocs again.
            iocs_q <= 1'b0;
            case (state_q)
                StCfgLo: begin
                    dout_q   <= baud_div(br_cfg)[7:0];
                    div_hi_q <= baud_div(br_cfg)[15:8];
                    iocs_q   <= 1'b1;
                    iorw_q   <= 1'b0;
                    ioaddr_q <= AddrDivLo;
                    ret_q    <= StCfgHi;
                    state_q  <= StGap;
                end
                StCfgHi: begin
                    dout_q   <= div_hi_q;
                    iocs_q   <= 1'b1;
                    iorw_q   <= 1'b0;
                    ioaddr_q <= AddrDivHi;
                    ret_q    <= StIdle;
                    state_q  <= StGap;
                end
                StIdle: begin
                    if (rda) begin
                        iocs_q   <= 1'b1;
                        iorw_q   <= 1'b1;
                        ioaddr_q <= AddrBuf;
                        ret_q    <= StRxOp;
                        state_q  <= StGap;
                    end
                end
                StRxOp: begin
                    cnt_q <= 3'd0;
                    if (rx_q[7:0] == OpWrite) begin
                        op_we_q <= 1'b1;
                        state_q <= StRxAddr;
                    end else if (rx_q[7:0] == OpRead) begin
                        op_we_q <= 1'b0;
                        state_q <= StRxAddr;
                    end else begin
`ifdef UART_ACK_EN
                        tx_q    <= {RspNak, 24'h0};
                        tx_n_q  <= 3'd1;
                        state_q <= StTxByte;
`else
                        state_q <= StIdle;
`endif
                    end
                end
                StRxAddr: begin
                    if (cnt_q == 3'd3) begin
                        cnt_q      <= 3'd0;
                        mem_addr_q <= rx_q[23:0];
                        if (op_we_q) begin
                            state_q <= StRxData;
                        end else begin
                            mem_req_q <= 1'b1;
                            mem_we_q  <= 1'b0;
                            state_q   <= StMemReq;
                        end
                    end else if (rda) begin
                        iocs_q   <= 1'b1;
                        iorw_q   <= 1'b1;
                        ioaddr_q <= AddrBuf;
                        cnt_q    <= cnt_q + 3'd1;
                        ret_q    <= StRxAddr;
                        state_q  <= StGap;
                    end
                end
                StRxData: begin
                    if (cnt_q == 3'd4) begin
                        cnt_q       <= 3'd0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= rx_q;
                        state_q     <= StMemReq;
                    end else if (rda) begin
                        iocs_q   <= 1'b1;
                        iorw_q   <= 1'b1;
                        ioaddr_q <= AddrBuf;
                        cnt_q    <= cnt_q + 3'd1;
                        ret_q    <= StRxData;
                        state_q  <= StGap;
                    end
                end
                StMemReq: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        cnt_q     <= 3'd0;
                        if (mem_we_q) begin
`ifdef UART_ACK_EN
                            tx_q    <= {RspAck, 24'h0};
                            tx_n_q  <= 3'd1;
                            state_q <= StTxByte;
`else
                            state_q <= StIdle;
`endif
                        end else if (mem_rvalid) begin
                            tx_q    <= mem_rdata;
                            tx_n_q  <= 3'd4;
                            state_q <= StTxByte;
                        end else begin
                            state_q <= StMemWait;
                        end
                    end
                end
                StMemWait: begin
                    if (mem_rvalid) begin
                        tx_q    <= mem_rdata;
                        tx_n_q  <= 3'd4;
                        cnt_q   <= 3'd0;
                        state_q <= StTxByte;
                    end
                end
                StTxByte: begin
                    if (cnt_q == tx_n_q) begin
                        state_q <= StIdle;
                    end else if (tbr) begin
                        dout_q   <= tx_q[31:24];
                        tx_q     <= {tx_q[23:0], 8'h00};
                        iocs_q   <= 1'b1;
                        iorw_q   <= 1'b0;
                        ioaddr_q <= AddrBuf;
                        cnt_q    <= cnt_q + 3'd1;
                        ret_q    <= StTxByte;
                        state_q  <= StGap;
                    end
                end
                StGap: begin
                    // The read access is the cycle just ending, so databus is valid on this edge.
                    if (iocs_q && iorw_q) begin
                        rx_q <= {rx_q[23:0], databus};
                    end
                    state_q <= ret_q;
                end
                default: state_q <= StCfgLo;
            endcase
        end
    end

    assign databus   = (iocs_q && !iorw_q) ? dout_q : 8'hzz;
    assign iocs      = iocs_q;
    assign iorw      = iorw_q;
    assign ioaddr    = ioaddr_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_mem_sequencer.sv
// Bench for uart_mem_sequencer: SPART and memory models, expected results from a frame-level
// reference model with its own memory image.
module tb_uart_mem_sequencer;

    typedef struct packed {
        logic        we;
        logic [23:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  br_cfg = 2'b01;
    logic        rda = 1'b0;
    logic        tbr_en = 1'b1;
    logic        tx_busy = 1'b0;
    logic        mem_ack = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [7:0]  rx_drv = 8'h00;
    wire         tbr = tbr_en & ~tx_busy;
    wire         iocs;
    wire         iorw;
    wire  [1:0]  ioaddr;
    wire  [7:0]  databus;
    wire         mem_req;
    wire         mem_we;
    wire  [23:0] mem_addr;
    wire  [31:0] mem_wdata;
    wire         busy;

    int checks = 0;
    int failures = 0;
    int req_cycles = 0;
    int gap_err = 0;
    int stab_err = 0;
    int deassert_err = 0;
    int tbr_err = 0;
    int rd_err = 0;
    int ack_dly = 1;
    int rv_dly = 1;
    int tx_lat = 2;

    cmd_t        cmd_q[$];
    logic [7:0]  tx_q[$];
    logic [9:0]  cfg_q[$];
    logic [31:0] phys_mem[logic [23:0]];
    logic [31:0] exp_mem[logic [23:0]];

    logic p_iocs = 1'b0;
    logic p_req = 1'b0;
    logic p_ack = 1'b0;
    cmd_t p_cmd = '0;

    assign databus = (iocs && iorw) ? rx_drv : 8'hzz;

    uart_mem_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .br_cfg    (br_cfg),
        .iocs      (iocs),
        .iorw      (iorw),
        .ioaddr    (ioaddr),
        .rda       (rda),
        .tbr       (tbr),
        .databus   (databus),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dflt(input logic [23:0] a);
        return {a[7:0], a} ^ 32'hC3A5_5A3C;
    endfunction

    // Bus monitor: records SPART writes and memory commands, counts protocol violations.
    initial begin
        forever begin
            @(negedge clk);
            if (iocs && p_iocs) gap_err++;
            if (iocs && !iorw) begin
                if (ioaddr == 2'b00) begin
                    tx_q.push_back(databus);
                    if (!tbr) tbr_err++;
                end else begin
                    cfg_q.push_back({ioaddr, databus});
                end
            end
            if (iocs && iorw && !rda) rd_err++;
            if (mem_req) req_cycles++;
            if (mem_req && p_req && !p_ack && {mem_we, mem_addr, mem_wdata} != p_cmd) stab_err++;
            if (p_req && p_ack && mem_req) deassert_err++;
            if (mem_req && mem_ack) cmd_q.push_back({mem_we, mem_addr, mem_wdata});
            p_iocs = iocs;
            p_req  = mem_req;
            p_ack  = mem_ack;
            p_cmd  = {mem_we, mem_addr, mem_wdata};
        end
    end

    // SPART transmitter: buffer goes busy for tx_lat cycles after each buffer write.
    initial begin
        forever begin
            @(negedge clk);
            if (iocs && !iorw && ioaddr == 2'b00) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (tx_lat) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Memory controller: ack after ack_dly cycles of mem_req; read data rv_dly cycles after ack.
    initial begin
        logic        we;
        logic [31:0] rv;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req && !rst) begin
                repeat (ack_dly - 1) begin
                    @(posedge clk);
                    #1;
                end
                we = mem_we;
                if (we) phys_mem[mem_addr] = mem_wdata;
                rv = phys_mem.exists(mem_addr) ? phys_mem[mem_addr] : dflt(mem_addr);
                mem_ack = 1'b1;
                if (!we && rv_dly == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rv;
                end
                @(posedge clk);
                #1;
                mem_ack    = 1'b0;
                mem_rvalid = 1'b0;
                if (!we && rv_dly > 0) begin
                    repeat (rv_dly - 1) begin
                        @(posedge clk);
                        #1;
                    end
                    mem_rvalid = 1'b1;
                    mem_rdata  = rv;
                    @(posedge clk);
                    #1;
                    mem_rvalid = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic rx_byte(input logic [7:0] b);
        bit got = 1'b0;
        @(posedge clk);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        rx_drv = b;
        rda    = 1'b1;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if (iocs && iorw && ioaddr == 2'b00) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL rx_read: byte %02h got no read access, required one", b);
        end
        @(posedge clk);
        #1 rda = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit idle = 1'b0;
        for (int n = 0; n < 3000 && !idle; n++) begin
            @(negedge clk);
            if (!busy && !tx_busy) idle = 1'b1;
        end
        checks++;
        if (!idle) begin
            failures++;
            $display("FAIL %s_idle: busy=%0b, required 0", nm, busy);
        end
    endtask

    task automatic do_reset(input logic [1:0] cfg, input string nm);
        logic [15:0] div;
        bit          idle = 1'b0;
        case (cfg)
            2'b00:   div = 16'h0515;
            2'b01:   div = 16'h028A;
            2'b10:   div = 16'h0145;
            default: div = 16'h00A2;
        endcase
        @(negedge clk);
        rst = 1'b1;
        rda = 1'b0;
        tbr_en = 1'b1;
        br_cfg = cfg;
        repeat (2) @(negedge clk);
        checks++;
        if ({iocs, iorw, ioaddr, mem_req, mem_we, mem_addr, mem_wdata, busy} !==
            {1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 24'h0, 32'h0, 1'b1}) begin
            failures++;
            $display("FAIL %s_rstvals: iocs=%b iorw=%b ioaddr=%b req=%b we=%b addr=%h wd=%h busy=%b, required 0 1 00 0 0 000000 00000000 1",
                     nm, iocs, iorw, ioaddr, mem_req, mem_we, mem_addr, mem_wdata, busy);
        end
        cfg_q.delete();
        rst = 1'b0;
        @(posedge clk);
        #1 br_cfg = ~cfg;
        for (int n = 0; n < 20 && !idle; n++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        checks++;
        if (!idle) begin
            failures++;
            $display("FAIL %s_cfg_idle: busy=%b, required 0", nm, busy);
        end
        checks++;
        if (cfg_q.size() != 2 || cfg_q[0] !== {2'b10, div[7:0]} || cfg_q[1] !== {2'b11, div[15:8]}) begin
            failures++;
            $display("FAIL %s_divisor: writes=%p, required [%h,%h]", nm, cfg_q,
                     {2'b10, div[7:0]}, {2'b11, div[15:8]});
        end
    endtask

    // Frame-level reference model: builds the byte stream, predicts the command and TX bytes.
    task automatic run_frame(input logic [7:0] op, input logic [23:0] addr, input logic [31:0] data,
                             input string nm);
        logic [7:0]  bytes[$];
        logic [7:0]  etx[$];
        cmd_t        ecmd[$];
        logic [31:0] v;
        bit          bad;
        cmd_q.delete();
        tx_q.delete();
        bytes.push_back(op);
        if (op == 8'h57 || op == 8'h52) begin
            for (int i = 2; i >= 0; i--) bytes.push_back(addr[8*i +: 8]);
        end
        if (op == 8'h57) begin
            for (int i = 3; i >= 0; i--) bytes.push_back(data[8*i +: 8]);
            ecmd.push_back({1'b1, addr, data});
            exp_mem[addr] = data;
`ifdef UART_ACK_EN
            etx.push_back(8'h06);
`endif
        end else if (op == 8'h52) begin
            ecmd.push_back({1'b0, addr, 32'h0});
            v = exp_mem.exists(addr) ? exp_mem[addr] : dflt(addr);
            for (int i = 3; i >= 0; i--) etx.push_back(v[8*i +: 8]);
        end else begin
`ifdef UART_ACK_EN
            etx.push_back(8'h15);
`endif
        end
        foreach (bytes[i]) rx_byte(bytes[i]);
        wait_idle(nm);
        checks++;
        bad = cmd_q.size() != ecmd.size();
        if (!bad && ecmd.size() == 1) begin
            bad = cmd_q[0].we !== ecmd[0].we || cmd_q[0].addr !== ecmd[0].addr ||
                  (ecmd[0].we && cmd_q[0].wdata !== ecmd[0].wdata);
        end
        if (bad) begin
            failures++;
            $display("FAIL %s_cmd: got %p, required %p", nm, cmd_q, ecmd);
        end
        checks++;
        bad = tx_q.size() != etx.size();
        foreach (etx[i]) if (i < tx_q.size() && tx_q[i] !== etx[i]) bad = 1'b1;
        if (bad) begin
            failures++;
            $display("FAIL %s_tx: got %p, required %p", nm, tx_q, etx);
        end
    endtask

    task automatic test_reset();
        int start = $urandom_range(0, 3);
        for (int i = 0; i < 4; i++) do_reset(2'((start + i) % 4), "reset");
        do_reset(2'b01, "reset_9600");
    endtask

    task automatic test_write();
        ack_dly = 3;
        req_cycles = 0;
        run_frame(8'h57, 24'h001234, 32'hDEADBEEF, "write");
        checks++;
        if (req_cycles != 3) begin
            failures++;
            $display("FAIL write_req_len: mem_req high %0d cycles, required 3", req_cycles);
        end
    endtask

    task automatic test_read();
        phys_mem[24'hABCDEF] = 32'h01020304;
        exp_mem[24'hABCDEF]  = 32'h01020304;
        ack_dly = 2;
        rv_dly  = 3;
        tx_lat  = 6;
        run_frame(8'h52, 24'hABCDEF, 32'h0, "read");
    endtask

    task automatic test_bad_opcode();
        run_frame(8'h41, 24'h0, 32'h0, "badop");
        run_frame(8'h52, 24'h000010, 32'h0, "badop_next");
    endtask

    task automatic test_reset_mid();
        cmd_q.delete();
        rx_byte(8'h52);
        rx_byte(8'hAB);
        rx_byte(8'hCD);
        do_reset(2'b11, "midrst");
        checks++;
        if (cmd_q.size() != 0) begin
            failures++;
            $display("FAIL midrst_nocmd: %0d commands, required 0", cmd_q.size());
        end
        rv_dly = 1;
        run_frame(8'h52, 24'h112233, 32'h0, "midrst_read");
    endtask

    task automatic test_same_cycle();
        logic [7:0] etx[$];
        bit         bad;
        phys_mem[24'h0A0B0C] = 32'hCAFEF00D;
        exp_mem[24'h0A0B0C]  = 32'hCAFEF00D;
        for (int i = 3; i >= 0; i--) etx.push_back(exp_mem[24'h0A0B0C][8*i +: 8]);
        ack_dly = 1;
        rv_dly  = 0;
        tx_lat  = 2;
        cmd_q.delete();
        tx_q.delete();
        tbr_en = 1'b0;
        rx_byte(8'h52);
        rx_byte(8'h0A);
        rx_byte(8'h0B);
        rx_byte(8'h0C);
        repeat (50) @(posedge clk);
        checks++;
        if (tx_q.size() != 0 || cmd_q.size() != 1) begin
            failures++;
            $display("FAIL same_stall: tx=%0d cmds=%0d, required 0 and 1", tx_q.size(), cmd_q.size());
        end
        #1 tbr_en = 1'b1;
        wait_idle("same");
        checks++;
        bad = tx_q.size() != 4;
        foreach (etx[i]) if (i < tx_q.size() && tx_q[i] !== etx[i]) bad = 1'b1;
        if (bad) begin
            failures++;
            $display("FAIL same_tx: got %p, required %p", tx_q, etx);
        end
    endtask

    task automatic test_random();
        logic [23:0] pool[4];
        logic [7:0]  op;
        for (int i = 0; i < 4; i++) pool[i] = 24'($urandom);
        for (int f = 0; f < 24; f++) begin
            int sel = $urandom_range(0, 6);
            ack_dly = $urandom_range(1, 4);
            rv_dly  = $urandom_range(0, 3);
            tx_lat  = $urandom_range(1, 5);
            if (sel < 3) begin
                op = 8'h57;
            end else if (sel < 6) begin
                op = 8'h52;
            end else begin
                op = 8'($urandom);
                if (op == 8'h57 || op == 8'h52) op = 8'h00;
            end
            run_frame(op, pool[$urandom_range(0, 3)], $urandom, "random");
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (gap_err != 0) begin
            failures++;
            $display("FAIL proto_gap: %0d back-to-back iocs cycles, required 0", gap_err);
        end
        checks++;
        if (stab_err != 0) begin
            failures++;
            $display("FAIL proto_stable: %0d command changes before ack, required 0", stab_err);
        end
        checks++;
        if (deassert_err != 0) begin
            failures++;
            $display("FAIL proto_deassert: %0d late mem_req drops, required 0", deassert_err);
        end
        checks++;
        if (tbr_err != 0) begin
            failures++;
            $display("FAIL proto_tbr: %0d writes while tbr=0, required 0", tbr_err);
        end
        checks++;
        if (rd_err != 0) begin
            failures++;
            $display("FAIL proto_rda: %0d reads while rda=0, required 0", rd_err);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_opcode();
        test_reset_mid();
        test_same_cycle();
        test_random();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_mem_sequencer.md
UART_MEM_SEQUENCER -- requirements
Module: uart_mem_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, 100 MHz system clock; sole clock.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port br_cfg, input, 2, baud select: 00=4800, 01=9600, 10=19200, 11=38400.
REQ-004 SHALL have ports iocs output 1 (SPART select), iorw output 1 (1=read, 0=write), ioaddr output 2 (00=tx/rx buffer, 01=status, 10=divisor low, 11=divisor high).
REQ-005 SHALL have ports rda input 1 (receive data available) and tbr input 1 (transmit buffer ready).
REQ-006 SHALL have port databus, inout, 8; driven only while iocs=1 and iorw=0, otherwise high-Z.
REQ-007 SHALL have ports mem_req output 1, mem_we output 1, mem_addr output 24, mem_wdata output 32, i.e. the memory-controller command interface.
REQ-008 SHALL have ports mem_ack input 1 (command accepted), mem_rvalid input 1 and mem_rdata input 32 (read return).
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-010 SHALL implement states CFG_LO, CFG_HI, IDLE, RX_OP, RX_ADDR, RX_DATA, MEM_REQ, MEM_WAIT, TX_BYTE, GAP.
REQ-011 SHALL, in CFG_LO then CFG_HI, write divisor low then high byte (iocs=1, iorw=0, ioaddr=10/11), one cycle each: 4800->0x0515, 9600->0x028A, 19200->0x0145, 38400->0x00A2.
REQ-012 SHALL sample br_cfg only in CFG_LO; later changes take effect only after reset.
REQ-013 SHALL perform each SPART access as exactly one cycle of iocs=1 and follow it with one GAP cycle (iocs=0) before the next access or status test.
REQ-014 SHALL read a byte only when rda=1 (iocs=1, iorw=1, ioaddr=00), capturing databus on that same clock edge.
REQ-015 SHALL accept frame opcode 0x57 'W' + 3 address bytes + 4 data bytes, or opcode 0x52 'R' + 3 address bytes; all fields MSB first.
REQ-016 SHALL discard any other opcode byte and return to IDLE, with no memory command issued.
REQ-017 SHALL, in MEM_REQ, hold mem_req=1 with mem_we, mem_addr and mem_wdata stable until the cycle mem_ack=1; mem_req SHALL deassert the following cycle.
REQ-018 SHALL, for a write, return to IDLE after ack; for a read, wait in MEM_WAIT for mem_rvalid and latch mem_rdata on that edge.
REQ-019 SHALL accept mem_ack and mem_rvalid asserted in the same cycle and latch rdata then.
REQ-020 SHALL transmit the 4 read-data bytes MSB first, each written (iocs=1, iorw=0, ioaddr=00) only when tbr=1.
REQ-021 SHALL keep a 3-bit byte counter; it SHALL clear on entry to each multi-byte field and never wrap inside a frame.
REQ-022 SHALL NOT time out; a frame stalls indefinitely awaiting rda, tbr, mem_ack or mem_rvalid.

Reset
REQ-023 SHALL on rst force state=CFG_LO, iocs=0, iorw=1, ioaddr=00, databus high-Z, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=1, counter=0.
REQ-024 SHALL abandon any partial frame or outstanding memory command on reset mid-operation and reprogram the divisor afterwards.

Configuration
REQ-025 SHALL, with UART_ACK_EN defined, transmit 0x06 after each write ack and 0x15 after each discarded opcode (tbr-gated, per REQ-020); without it, no response byte is sent for writes or bad opcodes.

Verification
REQ-026 Reset release, br_cfg=01 -> divisor writes 0x8A@ioaddr 10, then 0x02@ioaddr 11, then busy=0 in IDLE.
REQ-027 RX bytes 57 00 12 34 DE AD BE EF, mem_ack after 3 cycles -> mem_req held 3 cycles, mem_we=1, mem_addr=0x001234, mem_wdata=0xDEADBEEF; 0x06 sent only if UART_ACK_EN.
REQ-028 RX 52 AB CD EF, mem_rvalid with mem_rdata=0x01020304 -> mem_we=0, mem_addr=0xABCDEF; TX 01,02,03,04, each only while tbr=1.
REQ-029 RX opcode 0x41 -> no mem_req, IDLE next frame; 0x15 sent only with UART_ACK_EN.
REQ-030 rst asserted after 2 address bytes -> all outputs at reset values; a new complete 'R' frame then executes correctly.
REQ-031 Read with mem_ack and mem_rvalid in the same cycle, tbr low 50 cycles -> rdata latched, no SPART write until tbr=1.
